i2c_init_master: RTL

Bit-level I2C master that walks an init ROM (address/data bytes indexed by transaction, message and bit) and serialises it onto SCL/SDA. Sits directly downstream of the ADV7511 init ROM: it drives `index_bit`/`index_msg`/`index_trans`, reads back `msg_bit` and the `LIMIT_*` bounds, and runs the full write sequence once per `start` request. Write-only; every byte must be ACKed.

---
 rtl/i2c_init_master.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/i2c_init_master.sv
// Bit-level I2C write master that walks an external init ROM.
// Indices go out to the ROM, the addressed bit comes back on msg_bit, and the
// sequence START / 9 bits per byte / STOP / GAP is run once per start request.
// Every phase is four SCL quarters long; a quarter is CLK_DIV clock cycles.
module i2c_init_master #(
  parameter int BI_BW   = 3,
  parameter int MI_BW   = 2,
  parameter int TI_BW   = 5,
  parameter int CLK_DIV = 125
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic [BI_BW-1:0] index_bit,
  output logic [MI_BW-1:0] index_msg,
  output logic [TI_BW-1:0] index_trans,
  input  logic [BI_BW-1:0] LIMIT_BIT,
  input  logic [MI_BW-1:0] LIMIT_MSG,
  input  logic [TI_BW-1:0] LIMIT_TRANS,
  input  logic             msg_bit,
  output logic             scl,
  output logic             sda_oe,
  input  logic             sda_in,
  output logic             busy,
  output logic             done,
  output logic             nack_error
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_GAP, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       qtr_q, qtr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BI_BW-1:0] ib_q, ib_d;
  logic [MI_BW-1:0] im_q, im_d;
  logic [TI_BW-1:0] it_q, it_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             nack_q, nack_d;
  logic             abort_q, abort_d;
  logic             bit_q, bit_d;
  logic             ack_q, ack_d;
  logic             tick, last;

  assign tick = (cnt_q == CNT_MAX);
  assign last = tick && (qtr_q == 2'd3);

  // State register; reset drops straight back to an idle, released bus.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      qtr_q   <= '0;
      cnt_q   <= '0;
      ib_q    <= '0;
      im_q    <= '0;
      it_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      nack_q  <= 1'b0;
      abort_q <= 1'b0;
      bit_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      qtr_q   <= qtr_d;
      cnt_q   <= cnt_d;
      ib_q    <= ib_d;
      im_q    <= im_d;
      it_q    <= it_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      nack_q  <= nack_d;
      abort_q <= abort_d;
      bit_q   <= bit_d;
      ack_q   <= ack_d;
    end
  end

  // Quarter timing, index walking and phase sequencing.
  always_comb begin
    state_d = state_q;
    qtr_d   = qtr_q;
    cnt_d   = cnt_q;
    ib_d    = ib_q;
    im_d    = im_q;
    it_d    = it_q;
    busy_d  = busy_q;
    done_d  = done_q;
    nack_d  = nack_q;
    abort_d = abort_q;
    bit_d   = bit_q;
    ack_d   = ack_q;

    if (state_q == S_IDLE || state_q == S_DONE) begin
      cnt_d = '0;
      qtr_d = '0;
    end else begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
      if (tick) qtr_d = qtr_q + 2'd1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_START;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          nack_d  = 1'b0;
          abort_d = 1'b0;
          ib_d    = '0;
          im_d    = '0;
          it_d    = '0;
        end
      end
      S_START: if (last) state_d = S_BIT;
      S_BIT: begin
        // Grab the ROM bit on the first cycle of q0: the indices moved on the
        // previous tick, so the ROM has had a full cycle to settle.
        if (qtr_q == 2'd0 && cnt_q == '0) bit_d = msg_bit;
        if (last) begin
          if (ib_q == LIMIT_BIT) begin
            ib_d    = '0;
            state_d = S_ACK;
          end else begin
            ib_d = ib_q + BI_BW'(1);
          end
        end
      end
      S_ACK: begin
        if (tick && qtr_q == 2'd2) ack_d = sda_in;
        if (last) begin
          if (ack_q) begin
            nack_d  = 1'b1;
            abort_d = 1'b1;
            state_d = S_STOP;
          end else if (im_q == LIMIT_MSG) begin
            state_d = S_STOP;
          end else begin
            im_d    = im_q + MI_BW'(1);
            state_d = S_BIT;
          end
        end
      end
      S_STOP: if (last) state_d = S_GAP;
      S_GAP: begin
        if (last) begin
          if (abort_q || it_q == LIMIT_TRANS) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            it_d    = it_q + TI_BW'(1);
            im_d    = '0;
            state_d = S_START;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus levels decoded from phase and quarter; SDA only moves with SCL low
  // except the START fall (q2) and the STOP rise (q2).
  always_comb begin
    scl    = 1'b1;
    sda_oe = 1'b0;
    case (state_q)
      S_START: begin
        scl    = (qtr_q != 2'd3);
        sda_oe = qtr_q[1];
      end
      S_BIT: begin
        scl    = qtr_q[1];
        sda_oe = ~bit_q;
      end
      S_ACK: scl = qtr_q[1];
      S_STOP: begin
        scl    = (qtr_q != 2'd0);
        sda_oe = ~qtr_q[1];
      end
      default: ;
    endcase
  end

  assign index_bit   = ib_q;
  assign index_msg   = im_q;
  assign index_trans = it_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign nack_error  = nack_q;

endmodule
